// File: rtl/vm1_tve_bus.sv
// Bus front end for the VM1 on-chip timer.
// Maps the timer limit, counter and CSR registers onto a Wishbone slave port.
// It also answers CPU vector fetches for the timer interrupt.
//
// Ports
//   tve_clk, tve_reset              clock, asynchronous active-high reset
//   wb_*                            Wishbone slave (16-bit, byte lanes via wb_sel_i)
//   tve_din / tve_dout              write data to / read data from the timer
//   tve_{csr,cnt,lim}_oe            one-cycle timer read selects
//   tve_{csr,lim}_wr                one-cycle timer write strobes
//   tve_irq / tve_ack               timer interrupt request / acknowledge pulse
//   vec_irq_o, vec_stb_i,
//   vec_ack_o, vec_dat_o            CPU interrupt request and vector-fetch handshake
//
// Bus FSM
//   state   | meaning
//   B_IDLE  | waiting for a decoded strobe; latches the request
//   B_READ  | one OE cycle; timer data captured at the end
//   B_WRITE | one write-strobe cycle with tve_din valid
//   B_ACK   | single-cycle wb_ack_o
//   B_WAIT  | holds until the master drops wb_stb_i
//
// Interrupt FSM
//   state   | meaning
//   V_IDLE  | passes tve_irq to the CPU, waits for a vector fetch
//   V_ACK   | single-cycle vector acknowledge with vector on vec_dat_o
//   V_WAIT  | holds until the CPU drops vec_stb_i

module vm1_tve_bus #(
    parameter logic [15:0] TVE_BASE = 16'o177706,
    parameter logic [15:0] TVE_VEC  = 16'o000270
) (
    input  logic        tve_clk,
    input  logic        tve_reset,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [15:0] tve_din,
    input  logic [15:0] tve_dout,
    output logic        tve_csr_oe,
    output logic        tve_cnt_oe,
    output logic        tve_lim_oe,
    output logic        tve_csr_wr,
    output logic        tve_lim_wr,
    input  logic        tve_irq,
    output logic        tve_ack,
    output logic        vec_irq_o,
    input  logic        vec_stb_i,
    output logic        vec_ack_o,
    output logic [15:0] vec_dat_o
);

    localparam logic [15:0] ADR_LIM = TVE_BASE;
    localparam logic [15:0] ADR_CNT = TVE_BASE + 16'd2;
    localparam logic [15:0] ADR_CSR = TVE_BASE + 16'd4;

    typedef enum logic [1:0] {REG_LIM, REG_CNT, REG_CSR, REG_NONE} reg_t;
    typedef enum logic [2:0] {B_IDLE, B_READ, B_WRITE, B_ACK, B_WAIT} bus_state_t;
    typedef enum logic [1:0] {V_IDLE, V_ACK, V_WAIT} vec_state_t;

    bus_state_t bus_state, bus_next;
    vec_state_t vec_state, vec_next;
    reg_t       dec, reg_q;
    logic       hit;
    logic       we_q;
    logic [1:0] sel_q;
    logic [15:0] dat_q;

    // Byte address bit 0 never takes part in decode.
    logic unused_adr0;
    assign unused_adr0 = wb_adr_i[0];

    always_comb begin
        dec = REG_NONE;
        if (wb_adr_i[15:1] == ADR_LIM[15:1])
            dec = REG_LIM;
        else if (wb_adr_i[15:1] == ADR_CNT[15:1])
            dec = REG_CNT;
        else if (wb_adr_i[15:1] == ADR_CSR[15:1])
            dec = REG_CSR;
    end

    assign hit = wb_cyc_i & wb_stb_i & (dec != REG_NONE);

    always_ff @(posedge tve_clk or posedge tve_reset) begin
        if (tve_reset) begin
            bus_state <= B_IDLE;
            reg_q     <= REG_NONE;
            we_q      <= 1'b0;
            sel_q     <= 2'b00;
            dat_q     <= 16'h0000;
            wb_dat_o  <= 16'h0000;
            tve_din   <= 16'h0000;
        end else begin
            bus_state <= bus_next;
            if (bus_state == B_IDLE && hit) begin
                reg_q <= dec;
                we_q  <= wb_we_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
                // Word writes skip READ, so tve_din is loaded directly here.
                if (wb_we_i && wb_sel_i == 2'b11)
                    tve_din <= wb_dat_i;
            end
            if (bus_state == B_READ) begin
                wb_dat_o <= tve_dout;
                // Byte-write merge: unselected lanes keep the register's current value.
                tve_din  <= {sel_q[1] ? dat_q[15:8] : tve_dout[15:8],
                             sel_q[0] ? dat_q[7:0]  : tve_dout[7:0]};
            end
        end
    end

    always_comb begin
        bus_next   = bus_state;
        tve_lim_oe = 1'b0;
        tve_cnt_oe = 1'b0;
        tve_csr_oe = 1'b0;
        tve_lim_wr = 1'b0;
        tve_csr_wr = 1'b0;
        wb_ack_o   = 1'b0;
        case (bus_state)
            B_IDLE: begin
                if (hit)
                    bus_next = (wb_we_i && wb_sel_i == 2'b11) ? B_WRITE : B_READ;
            end
            B_READ: begin
                tve_lim_oe = (reg_q == REG_LIM);
                tve_cnt_oe = (reg_q == REG_CNT);
                tve_csr_oe = (reg_q == REG_CSR);
                bus_next   = we_q ? B_WRITE : B_ACK;
            end
            B_WRITE: begin
                // The counter has no write strobe; such writes are acked and dropped.
                tve_lim_wr = (reg_q == REG_LIM);
                tve_csr_wr = (reg_q == REG_CSR);
                bus_next   = B_ACK;
            end
            B_ACK: begin
                wb_ack_o = 1'b1;
                bus_next = B_WAIT;
            end
            B_WAIT: begin
                if (!wb_stb_i)
                    bus_next = B_IDLE;
            end
            default: bus_next = B_IDLE;
        endcase
    end

    always_ff @(posedge tve_clk or posedge tve_reset) begin
        if (tve_reset)
            vec_state <= V_IDLE;
        else
            vec_state <= vec_next;
    end

    always_comb begin
        vec_next  = vec_state;
        vec_irq_o = 1'b0;
        vec_ack_o = 1'b0;
        tve_ack   = 1'b0;
        vec_dat_o = 16'h0000;
        case (vec_state)
            V_IDLE: begin
                vec_irq_o = tve_irq & ~tve_reset;
                if (vec_stb_i && tve_irq)
                    vec_next = V_ACK;
            end
            V_ACK: begin
                vec_ack_o = 1'b1;
                tve_ack   = 1'b1;
                vec_dat_o = TVE_VEC;
                vec_next  = V_WAIT;
            end
            V_WAIT: begin
                if (!vec_stb_i)
                    vec_next = V_IDLE;
            end
            default: vec_next = V_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vm1_tve_bus.sv
// Self-checking bench for vm1_tve_bus: directed scenarios plus randomized
// bus accesses checked against a register-level model of the timer.

module tb_vm1_tve_bus;

    localparam logic [15:0] A_LIM  = 16'o177706;
    localparam logic [15:0] A_CNT  = 16'o177710;
    localparam logic [15:0] A_CSR  = 16'o177712;
    localparam logic [15:0] A_MISS = 16'o177714;
    localparam logic [15:0] VEC    = 16'o000270;

    logic        tve_clk = 1'b0;
    logic        tve_reset;
    logic [15:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
    logic [1:0]  wb_sel_i;
    logic [15:0] tve_din, tve_dout;
    logic        tve_csr_oe, tve_cnt_oe, tve_lim_oe, tve_csr_wr, tve_lim_wr;
    logic        tve_irq, tve_ack, vec_irq_o, vec_stb_i, vec_ack_o;
    logic [15:0] vec_dat_o;

    // Timer register model; the timer drives tve_dout only under an OE.
    logic [15:0] m_lim, m_cnt, m_csr;
    assign tve_dout = tve_lim_oe ? m_lim : tve_cnt_oe ? m_cnt : tve_csr_oe ? m_csr : 16'hDEAD;

    int n_pass = 0;
    int n_total = 0;

    // Observations of the most recent bus access.
    int o_ack_cyc, o_ack_n, o_lim_oe, o_cnt_oe, o_csr_oe, o_lim_wr, o_csr_wr, o_excl;
    logic [15:0] o_din, o_rdata;

    always #5 tve_clk = ~tve_clk;

    vm1_tve_bus dut (
        .tve_clk(tve_clk), .tve_reset(tve_reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
        .tve_din(tve_din), .tve_dout(tve_dout),
        .tve_csr_oe(tve_csr_oe), .tve_cnt_oe(tve_cnt_oe), .tve_lim_oe(tve_lim_oe),
        .tve_csr_wr(tve_csr_wr), .tve_lim_wr(tve_lim_wr),
        .tve_irq(tve_irq), .tve_ack(tve_ack),
        .vec_irq_o(vec_irq_o), .vec_stb_i(vec_stb_i),
        .vec_ack_o(vec_ack_o), .vec_dat_o(vec_dat_o)
    );

    // Drives one access with the strobe held for six cycles, then releases it
    // and records every OE/WR/ack seen. Starts and ends 1 time unit after a rising edge.
    task automatic run_access(input logic [15:0] adr, input logic we,
                              input logic [1:0] sel, input logic [15:0] dat);
        o_ack_cyc = 0; o_ack_n = 0; o_lim_oe = 0; o_cnt_oe = 0; o_csr_oe = 0;
        o_lim_wr = 0; o_csr_wr = 0; o_excl = 0; o_din = 16'hxxxx; o_rdata = 16'hxxxx;
        wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; wb_dat_i = dat;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 7) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
            @(posedge tve_clk); #1;
            if (wb_ack_o) begin
                o_ack_n++;
                if (o_ack_cyc == 0) begin
                    o_ack_cyc = k;
                    o_rdata = wb_dat_o;
                end
            end
            o_lim_oe += int'(tve_lim_oe);
            o_cnt_oe += int'(tve_cnt_oe);
            o_csr_oe += int'(tve_csr_oe);
            o_lim_wr += int'(tve_lim_wr);
            o_csr_wr += int'(tve_csr_wr);
            if (int'(tve_lim_oe) + int'(tve_cnt_oe) + int'(tve_csr_oe) +
                int'(tve_lim_wr) + int'(tve_csr_wr) > 1)
                o_excl++;
            if (tve_lim_wr) begin o_din = tve_din; m_lim = tve_din; end
            if (tve_csr_wr) begin o_din = tve_din; m_csr = tve_din; end
        end
    endtask

    task automatic test_reset;
        tve_reset = 1'b1; tve_irq = 1'b1; vec_stb_i = 1'b0;
        wb_adr_i = 16'h0; wb_dat_i = 16'h0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        wb_we_i = 1'b0; wb_sel_i = 2'b00;
        m_lim = 16'($urandom); m_cnt = 16'($urandom); m_csr = 16'($urandom);
        #3;
        n_total++;
        if ({wb_dat_o, tve_din, vec_dat_o} !== 48'h0) begin
            $display("FAIL reset_data: wb_dat_o=%h tve_din=%h vec_dat_o=%h, want 0", wb_dat_o, tve_din, vec_dat_o);
        end else n_pass++;
        repeat (2) @(posedge tve_clk);
        #1;
        n_total++;
        if ({tve_lim_oe, tve_cnt_oe, tve_csr_oe, tve_lim_wr, tve_csr_wr, wb_ack_o, vec_ack_o, tve_ack, vec_irq_o} !== 9'b0) begin
            $display("FAIL reset_ctrl: oe/wr/ack/irq=%b, want 0", {tve_lim_oe, tve_cnt_oe, tve_csr_oe, tve_lim_wr, tve_csr_wr, wb_ack_o, vec_ack_o, tve_ack, vec_irq_o});
        end else n_pass++;
        tve_reset = 1'b0; tve_irq = 1'b0;
        @(posedge tve_clk); #1;
    endtask

    task automatic test_word_write;
        run_access(A_LIM, 1'b1, 2'b11, 16'o001234);
        n_total++;
        if (o_lim_wr !== 1 || o_csr_wr !== 0 || o_din !== 16'o001234) begin
            $display("FAIL ww_strobe: lim_wr=%0d csr_wr=%0d din=%o, want 1 0 001234", o_lim_wr, o_csr_wr, o_din);
        end else n_pass++;
        n_total++;
        if (o_ack_cyc !== 2 || o_ack_n !== 1) begin
            $display("FAIL ww_ack: cycle=%0d count=%0d, want 2 1", o_ack_cyc, o_ack_n);
        end else n_pass++;
        n_total++;
        if (o_lim_oe + o_cnt_oe + o_csr_oe !== 0) begin
            $display("FAIL ww_no_oe: oe cycles=%0d, want 0", o_lim_oe + o_cnt_oe + o_csr_oe);
        end else n_pass++;
    endtask

    task automatic test_read;
        m_csr = 16'o177621;
        run_access(A_CSR, 1'b0, 2'b11, 16'h0);
        n_total++;
        if (o_csr_oe !== 1 || o_lim_oe !== 0 || o_cnt_oe !== 0 || o_lim_wr + o_csr_wr !== 0) begin
            $display("FAIL rd_oe: csr=%0d lim=%0d cnt=%0d wr=%0d, want 1 0 0 0", o_csr_oe, o_lim_oe, o_cnt_oe, o_lim_wr + o_csr_wr);
        end else n_pass++;
        n_total++;
        if (o_ack_cyc !== 2 || o_rdata !== 16'o177621) begin
            $display("FAIL rd_data: cycle=%0d data=%o, want 2 177621", o_ack_cyc, o_rdata);
        end else n_pass++;
    endtask

    task automatic test_byte_write;
        m_lim = 16'hAB12;
        run_access(A_LIM, 1'b1, 2'b01, 16'h0055);
        n_total++;
        if (o_lim_oe !== 1 || o_lim_wr !== 1 || o_din !== 16'hAB55) begin
            $display("FAIL bw_merge: lim_oe=%0d lim_wr=%0d din=%h, want 1 1 ab55", o_lim_oe, o_lim_wr, o_din);
        end else n_pass++;
        n_total++;
        if (o_ack_cyc !== 3 || o_ack_n !== 1) begin
            $display("FAIL bw_ack: cycle=%0d count=%0d, want 3 1", o_ack_cyc, o_ack_n);
        end else n_pass++;
    endtask

    task automatic test_counter_and_miss;
        run_access(A_CNT, 1'b1, 2'b11, 16'($urandom));
        n_total++;
        if (o_ack_cyc !== 2 || o_lim_wr + o_csr_wr !== 0) begin
            $display("FAIL cnt_write: ack cycle=%0d wr=%0d, want 2 0", o_ack_cyc, o_lim_wr + o_csr_wr);
        end else n_pass++;
        run_access(A_MISS, 1'b1, 2'b11, 16'($urandom));
        n_total++;
        if (o_ack_n !== 0 || o_lim_oe + o_cnt_oe + o_csr_oe + o_lim_wr + o_csr_wr !== 0) begin
            $display("FAIL miss: acks=%0d strobes=%0d, want 0 0", o_ack_n, o_lim_oe + o_cnt_oe + o_csr_oe + o_lim_wr + o_csr_wr);
        end else n_pass++;
    endtask

    task automatic test_vector_during_read;
        int v_ack_cyc, v_ack_n, t_ack_n, v_bad_dat, v_irq_busy;
        logic irq_before, irq_after;
        logic [15:0] v_dat, exp_rd;
        v_ack_cyc = 0; v_ack_n = 0; t_ack_n = 0; v_bad_dat = 0; v_irq_busy = 0;
        v_dat = 16'h0;
        m_cnt = 16'($urandom);
        exp_rd = m_cnt;
        tve_irq = 1'b1;
        fork
            run_access(A_CNT, 1'b0, 2'b11, 16'h0);
            begin
                @(posedge tve_clk); #1;
                irq_before = vec_irq_o;
                vec_stb_i = 1'b1;
                for (int k = 1; k <= 4; k++) begin
                    @(posedge tve_clk); #1;
                    if (vec_ack_o) begin
                        v_ack_n++;
                        if (v_ack_cyc == 0) begin v_ack_cyc = k; v_dat = vec_dat_o; end
                    end else if (vec_dat_o !== 16'h0) v_bad_dat++;
                    t_ack_n += int'(tve_ack);
                    if (k >= 2 && vec_irq_o) v_irq_busy++;
                end
                vec_stb_i = 1'b0;
                @(posedge tve_clk); #1;
                irq_after = vec_irq_o;
            end
        join
        n_total++;
        if (v_ack_cyc !== 1 || v_ack_n !== 1 || t_ack_n !== 1 || v_dat !== VEC) begin
            $display("FAIL vec_ack: cycle=%0d acks=%0d tve_acks=%0d vec=%o, want 1 1 1 000270", v_ack_cyc, v_ack_n, t_ack_n, v_dat);
        end else n_pass++;
        n_total++;
        if (v_bad_dat !== 0 || irq_before !== 1'b1 || irq_after !== 1'b1 || v_irq_busy !== 0) begin
            $display("FAIL vec_irq: bad_dat=%0d irq_before=%b irq_after=%b irq_busy=%0d, want 0 1 1 0", v_bad_dat, irq_before, irq_after, v_irq_busy);
        end else n_pass++;
        n_total++;
        if (o_ack_cyc !== 2 || o_rdata !== exp_rd || o_cnt_oe !== 1) begin
            $display("FAIL vec_read: cycle=%0d data=%h cnt_oe=%0d, want 2 %h 1", o_ack_cyc, o_rdata, o_cnt_oe, exp_rd);
        end else n_pass++;
        // A fetch with no pending request must go unanswered.
        tve_irq = 1'b0;
        vec_stb_i = 1'b1;
        v_ack_n = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge tve_clk); #1;
            v_ack_n += int'(vec_ack_o) + int'(tve_ack);
        end
        vec_stb_i = 1'b0;
        @(posedge tve_clk); #1;
        n_total++;
        if (v_ack_n !== 0) begin
            $display("FAIL vec_no_irq: acks=%0d, want 0", v_ack_n);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_read;
        int acks, strobes;
        logic oe_seen, oe_in_reset;
        acks = 0; strobes = 0;
        wb_adr_i = A_CSR; wb_we_i = 1'b0; wb_sel_i = 2'b11; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge tve_clk); #1;
        oe_seen = tve_csr_oe;
        tve_reset = 1'b1;
        #1;
        oe_in_reset = tve_csr_oe;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                tve_reset = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
            @(posedge tve_clk); #1;
            acks += int'(wb_ack_o);
            strobes += int'(tve_lim_oe) + int'(tve_cnt_oe) + int'(tve_csr_oe) + int'(tve_lim_wr) + int'(tve_csr_wr);
        end
        n_total++;
        if (oe_seen !== 1'b1 || oe_in_reset !== 1'b0 || acks !== 0 || strobes !== 0) begin
            $display("FAIL rst_mid_read: oe=%b oe_rst=%b acks=%0d strobes=%0d, want 1 0 0 0", oe_seen, oe_in_reset, acks, strobes);
        end else n_pass++;
        m_csr = 16'($urandom);
        strobes = int'(m_csr);
        run_access(A_CSR, 1'b0, 2'b11, 16'h0);
        n_total++;
        if (o_ack_cyc !== 2 || o_ack_n !== 1 || int'(o_rdata) !== strobes) begin
            $display("FAIL rst_retry: cycle=%0d acks=%0d data=%h, want 2 1 %h", o_ack_cyc, o_ack_n, o_rdata, strobes[15:0]);
        end else n_pass++;
    endtask

    task automatic test_random;
        logic [15:0] adr, dat, old, exp_din;
        logic        we, hit, rd_phase, wr_strobe;
        logic [1:0]  sel;
        int          which, exp_lat;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: adr = A_LIM;
                1: adr = A_CNT;
                2: adr = A_CSR;
                3: adr = A_MISS;
                default: adr = 16'($urandom);
            endcase
            adr[0] = 1'($urandom);
            we  = 1'($urandom);
            sel = 2'($urandom_range(1, 3));
            dat = 16'($urandom);
            m_cnt = 16'($urandom);
            which = ((adr & 16'hFFFE) == A_LIM) ? 0 :
                    ((adr & 16'hFFFE) == A_CNT) ? 1 :
                    ((adr & 16'hFFFE) == A_CSR) ? 2 : -1;
            hit = (which >= 0);
            old = (which == 0) ? m_lim : (which == 1) ? m_cnt : m_csr;
            rd_phase  = hit && (!we || sel != 2'b11);
            wr_strobe = hit && we && which != 1;
            exp_lat = !hit ? 0 : (!we ? 2 : (sel == 2'b11 ? 2 : 3));
            exp_din = {sel[1] ? dat[15:8] : old[15:8], sel[0] ? dat[7:0] : old[7:0]};
            run_access(adr, we, sel, dat);
            n_total++;
            if (o_ack_cyc !== exp_lat || o_ack_n !== (hit ? 1 : 0)) begin
                $display("FAIL rnd_ack[%0d]: adr=%o we=%b sel=%b cycle=%0d acks=%0d, want %0d %0d", i, adr, we, sel, o_ack_cyc, o_ack_n, exp_lat, hit ? 1 : 0);
            end else n_pass++;
            n_total++;
            if (o_lim_oe !== ((rd_phase && which == 0) ? 1 : 0) || o_cnt_oe !== ((rd_phase && which == 1) ? 1 : 0) ||
                o_csr_oe !== ((rd_phase && which == 2) ? 1 : 0) || o_lim_wr !== ((wr_strobe && which == 0) ? 1 : 0) ||
                o_csr_wr !== ((wr_strobe && which == 2) ? 1 : 0) || o_excl !== 0) begin
                $display("FAIL rnd_strobes[%0d]: adr=%o we=%b sel=%b oe=%0d/%0d/%0d wr=%0d/%0d excl=%0d", i, adr, we, sel, o_lim_oe, o_cnt_oe, o_csr_oe, o_lim_wr, o_csr_wr, o_excl);
            end else n_pass++;
            if (wr_strobe) begin
                n_total++;
                if (o_din !== exp_din) begin
                    $display("FAIL rnd_din[%0d]: adr=%o sel=%b din=%h, want %h", i, adr, sel, o_din, exp_din);
                end else n_pass++;
            end
            if (hit && !we) begin
                n_total++;
                if (o_rdata !== old) begin
                    $display("FAIL rnd_rdata[%0d]: adr=%o data=%h, want %h", i, adr, o_rdata, old);
                end else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_word_write;
        test_read;
        test_byte_write;
        test_counter_and_miss;
        test_vector_during_read;
        test_reset_mid_read;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vm1_tve_bus.md
VM1_TVE_BUS -- requirements
Module: vm1_tve_bus

Interface
REQ-001 Parameter TVE_BASE, 16'o177706, address of limit register; counter at TVE_BASE+2, CSR at TVE_BASE+4.
REQ-002 Parameter TVE_VEC, 16'o000270, interrupt vector returned on acknowledge.
REQ-003 tve_clk  in  1  system clock; all state updates on its rising edge.
REQ-004 tve_reset  in  1  reset, asynchronous, active-high.
REQ-005 wb_adr_i  in  16  bus byte address; bit 0 is ignored for decode.
REQ-006 wb_dat_i  in  16  bus write data.
REQ-007 wb_dat_o  out  16  bus read data, registered.
REQ-008 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  bus cycle, strobe, write select.
REQ-009 wb_sel_i  in  2  byte lanes: [0] low byte, [1] high byte.
REQ-010 wb_ack_o  out  1  bus acknowledge.
REQ-011 tve_din  out  16  write data to timer.
REQ-012 tve_dout  in  16  read data from timer.
REQ-013 tve_csr_oe, tve_cnt_oe, tve_lim_oe  out  1 each  timer read selects.
REQ-014 tve_csr_wr, tve_lim_wr  out  1 each  timer write strobes.
REQ-015 tve_irq  in  1  timer interrupt request.
REQ-016 tve_ack  out  1  timer interrupt acknowledge pulse.
REQ-017 vec_irq_o  out  1  interrupt request to CPU.
REQ-018 vec_stb_i  in  1  CPU vector-fetch strobe.
REQ-019 vec_ack_o  out  1  vector-fetch acknowledge.
REQ-020 vec_dat_o  out  16  vector value.

Function
REQ-021 Hit = wb_cyc_i & wb_stb_i & (wb_adr_i[15:1] equals TVE_BASE[15:1], (TVE_BASE+2)[15:1] or (TVE_BASE+4)[15:1]); a non-hit produces no ack and no timer strobe.
REQ-022 Bus FSM states: IDLE, READ, WRITE, ACK, WAIT.
REQ-023 IDLE: on hit, latch address, data, sel and we; go to READ when the access is a read or a byte write (sel != 2'b11); go to WRITE when the access is a word write.
REQ-024 READ: assert exactly one OE matching the latched address for this one cycle; capture tve_dout at the end of the cycle.
REQ-025 READ exit: go to ACK for a read; go to WRITE for a byte write.
REQ-026 Read data to the bus: wb_dat_o = captured tve_dout.
REQ-027 Byte-write merge: tve_din takes unselected lanes from the captured value and selected lanes from latched wb_dat_i.
REQ-028 WRITE: pulse the strobe for the latched address for exactly one cycle, with tve_din valid in the same cycle; go to ACK.
REQ-029 Write strobe mapping: limit address -> tve_lim_wr; CSR address -> tve_csr_wr; counter address -> no strobe (write silently ignored, still acked).
REQ-030 ACK: wb_ack_o = 1 for exactly one cycle; go to WAIT.
REQ-031 WAIT: hold until wb_stb_i = 0, then go to IDLE, so a held strobe never repeats an access.
REQ-032 Bus latency from the first edge sampling the hit to ack: word write = 2 cycles; read = 2 cycles; byte write = 3 cycles.
REQ-033 OE and WR strobes are mutually exclusive and never asserted outside READ and WRITE.
REQ-034 Interrupt FSM states: IDLE, VACK, VWAIT.
REQ-035 vec_irq_o = tve_irq in interrupt-IDLE, 0 otherwise.
REQ-036 Interrupt IDLE, vec_stb_i & tve_irq: go to VACK; vec_stb_i with tve_irq = 0 produces no response.
REQ-037 VACK: vec_ack_o = 1 and tve_ack = 1 for exactly one cycle, vec_dat_o = TVE_VEC; go to VWAIT.
REQ-038 VWAIT: return to IDLE when vec_stb_i = 0.
REQ-039 vec_dat_o = 0 whenever vec_ack_o = 0.
REQ-040 Bus and interrupt FSMs are independent; simultaneous bus access and vector fetch both complete with unchanged latencies.

Reset
REQ-041 tve_reset clears both FSMs to IDLE, and wb_dat_o, tve_din and vec_dat_o to 0.
REQ-042 tve_reset forces all OE, WR and ack outputs low, and vec_irq_o low while asserted.
REQ-043 Reset mid-access: the access is abandoned with no ack and no further strobe; the master must retry.

Verification
REQ-044 Word write 16'o001234 to 177706 -> tve_lim_wr for exactly 1 cycle with tve_din=16'o001234, ack 2 cycles after stb sampled, single ack while stb held.
REQ-045 Read 177712 with tve_dout=16'o177621 -> tve_csr_oe 1 cycle, wb_dat_o=16'o177621 with ack at cycle 2.
REQ-046 Byte write sel=01, data 16'h0055 to 177706 while limit reads 16'hAB12 -> lim_oe cycle, then lim_wr with tve_din=16'hAB55, ack at cycle 3.
REQ-047 Write to 177710 -> ack, no tve_csr_wr/tve_lim_wr; access to 177714 -> no ack, no strobes.
REQ-048 tve_irq=1, vec_stb_i raised during a bus read -> vec_ack_o and tve_ack 1 cycle with vec_dat_o=16'o000270; read still acks at cycle 2.
REQ-049 tve_reset asserted in READ state -> no ack; next access completes normally.
